// File: rtl/rptr_empty_pkg.sv
// Shared pointer helpers for both sides of the dual-clock FIFO.
// Gray/binary conversions work on a 32-bit container, so any pointer width below 32 can use them.
package fifo_pkg;

  localparam int ADDRSIZE_DFLT = 8;
  localparam int PTRW          = ADDRSIZE_DFLT + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero bits above the real width leave the result unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-side FIFO pointer bundle: the read request and the write pointer go in; address, Gray pointer and flags come out.
// The rlevel/raempty signals exist only when RPTR_LEVEL_EN is defined.
interface rptr_empty_if #(parameter int ADDRSIZE = 8);
  logic                rinc;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
`ifdef RPTR_LEVEL_EN
  logic [ADDRSIZE:0]   rlevel;
  logic                raempty;
`endif

`ifdef RPTR_LEVEL_EN
  modport master (output rinc, wptr, input raddr, rptr, rempty, rlevel, raempty);
  modport slave  (input rinc, wptr, output raddr, rptr, rempty, rlevel, raempty);
`else
  modport master (output rinc, wptr, input raddr, rptr, rempty);
  modport slave  (input rinc, wptr, output raddr, rptr, rempty);
`endif
endinterface

// File: rtl/rptr_empty_sync_w2r.sv
// Two-flop synchronizer that brings the write Gray pointer into the read clock domain.
// The write side reuses the same structure as sync_r2w.
module sync_w2r #(
  parameter int W = 9
) (
  input  logic         rclk,
  input  logic         rrst,
  input  logic [W-1:0] wptr,
  output logic [W-1:0] rq2_wptr
);
  logic [W-1:0] rq1_wptr;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= wptr;
      rq2_wptr <= rq1_wptr;
    end
  end
endmodule

// File: rtl/rptr_empty.sv
// Read pointer and registered empty flag for the dual-clock FIFO.
// Optional feature macro RPTR_LEVEL_EN adds the fill level (rlevel) and the almost-empty flag (raempty).
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = ADDRSIZE_DFLT,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic         rclk,
  input  logic         rrst,
  rptr_empty_if.slave  bus
);
  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rq2_wptr;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic          rempty_q;

  sync_w2r #(.W(PW)) u_sync_w2r (
    .rclk     (rclk),
    .rrst     (rrst),
    .wptr     (bus.wptr),
    .rq2_wptr (rq2_wptr)
  );

  assign rbinnext  = rbin + PW'(bus.rinc & ~rempty_q);
  assign rgraynext = PW'(bin2gray(32'(rbinnext)));

  // Comparing the next pointer lets the last read raise empty on the same edge.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbinnext;
      rptr_q   <= rgraynext;
      rempty_q <= (rgraynext == rq2_wptr);
    end
  end

  assign bus.raddr  = rbin[ADDRSIZE-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.rempty = rempty_q;

`ifdef RPTR_LEVEL_EN
  logic [PW-1:0] rq2_wbin;
  logic [PW-1:0] rlevelnext;
  logic [PW-1:0] rlevel_q;
  logic          raempty_q;

  assign rq2_wbin   = PW'(gray2bin(32'(rq2_wptr)));
  assign rlevelnext = rq2_wbin - rbinnext;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rlevel_q  <= '0;
      raempty_q <= 1'b1;
    end else begin
      rlevel_q  <= rlevelnext;
      raempty_q <= (32'(rlevelnext) <= 32'(AEMPTY_THRESH));
    end
  end

  assign bus.rlevel  = rlevel_q;
  assign bus.raempty = raempty_q;
`endif
endmodule
